// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the memory port and status of mem_arbiter.
// The arbiter sits on the slave side; requesters and memory sit on the master side.
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        rw0;
    logic        rw1;
    logic [1:0]  size0;
    logic [1:0]  size1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] rdata;
    logic        m_en;
    logic        m_rw;
    logic [1:0]  m_size;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] dbus;
    logic        busy;

    modport slave (
        input  req0, req1, rw0, rw1, size0, size1,
        input  addr0, addr1, wdata0, wdata1, dbus,
        output gnt0, gnt1, done0, done1, rdata,
        output m_en, m_rw, m_size, mar, mdr, busy
    );

    modport master (
        output req0, req1, rw0, rw1, size0, size1,
        output addr0, addr1, wdata0, wdata1, dbus,
        input  gnt0, gnt1, done0, done1, rdata,
        input  m_en, m_rw, m_size, mar, mdr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port; every output is registered.
// Define ARB_RR_EN for round-robin tie-breaking, otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned ACC_TICKS = 2
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    // state  | meaning
    // IDLE   | port free, requests sampled every edge
    // ACCESS | m_en high, cnt counts down the remaining access cycles
    // DONE   | done pulse of the owner, one turnaround cycle before IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACC_TICKS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        m_en_q, m_en_d, m_rw_q, m_rw_d;
    logic [1:0]  m_size_q, m_size_d;
    logic [31:0] mar_q, mar_d, mdr_q, mdr_d;
    logic        busy_q, busy_d;
    logic        pick;

`ifdef ARB_RR_EN
    logic        last_q, last_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        rdata_d  = rdata_q;
        m_en_d   = m_en_q;
        m_rw_d   = m_rw_q;
        m_size_d = m_size_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        busy_d   = busy_q;
`ifdef ARB_RR_EN
        last_d   = last_q;
        // on a tie the requester not granted most recently wins
        pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
`else
        pick     = ~bus.req0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d  = ACCESS;
                    owner_d  = pick;
                    gnt0_d   = ~pick;
                    gnt1_d   = pick;
                    m_en_d   = 1'b1;
                    m_rw_d   = pick ? bus.rw1    : bus.rw0;
                    m_size_d = pick ? bus.size1  : bus.size0;
                    mar_d    = pick ? bus.addr1  : bus.addr0;
                    mdr_d    = pick ? bus.wdata1 : bus.wdata0;
                    cnt_d    = CNT_LOAD;
                    busy_d   = 1'b1;
`ifdef ARB_RR_EN
                    last_d   = pick;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    m_en_d  = 1'b0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    if (m_rw_q) begin
                        rdata_d = bus.dbus;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done0_d = 1'b0;
                done1_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata_q  <= '0;
            m_en_q   <= 1'b0;
            m_rw_q   <= 1'b0;
            m_size_q <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata_q  <= rdata_d;
            m_en_q   <= m_en_d;
            m_rw_q   <= m_rw_d;
            m_size_q <= m_size_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.rdata  = rdata_q;
    assign bus.m_en   = m_en_q;
    assign bus.m_rw   = m_rw_q;
    assign bus.m_size = m_size_q;
    assign bus.mar    = mar_q;
    assign bus.mdr    = mdr_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte-lane memory model behind the ACC_TICKS=2
// instance and a fixed-data port behind a second ACC_TICKS=1 instance.
module tb_mem_arbiter;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.ACC_TICKS(2)) u_dut (.clock(clock), .reset(reset), .bus(bus));
    mem_arbiter #(.ACC_TICKS(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [0:255];

    // little-endian byte lanes, zero-extended to the access width; outside 256 bytes is an IO stub
    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v;
        logic [7:0]  idx;
        v = 32'h0;
        if (a >= 32'd256) return 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            idx = a[7:0] + 8'(i);
            if (i <= int'(sz)) v[8*i +: 8] = mem[idx];
        end
        return v;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0]    <= 8'h78;
            mem[1]    <= 8'h56;
            mem[2]    <= 8'h34;
            mem[3]    <= 8'h12;
            mem[8'h41] <= 8'h77;
            mem[8'h80] <= 8'h80;
            mem[8'h81] <= 8'h00;
            mem[8'h82] <= 8'hFE;
            mem[8'h83] <= 8'hCA;
        end else if (bus.m_en && !bus.m_rw && bus.mar < 32'd256) begin
            for (int i = 0; i < 4; i++) begin
                if (i <= int'(bus.m_size)) mem[bus.mar[7:0] + 8'(i)] <= bus.mdr[8*i +: 8];
            end
        end
    end

    always_comb bus.dbus = (bus.m_en && bus.m_rw) ? mem_rd(bus.mar, bus.m_size) : 32'h0;
    always_comb bus1.dbus = bus1.m_en ? 32'h5A5A0001 : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            chk("done_excl", 32'(bus.done0 & bus.done1), 32'd0);
        end
    end

    // Edge 1 is the sampling edge: m_en must be seen after edges 1..2, done after edge 3.
    task automatic run_access(input string tag, input bit who, input logic rw,
                              input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int en_c, gnt_c, done_e;
        bit other;
        en_c = 0; gnt_c = 0; done_e = 0; other = 1'b0;
        @(negedge clock);
        if (!who) begin
            bus.req0 = 1'b1; bus.rw0 = rw; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.rw1 = rw; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = wd;
        end
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock); #1;
            if (bus.m_en) en_c++;
            if (who ? bus.gnt1 : bus.gnt0) gnt_c++;
            if (who ? bus.gnt0 : bus.gnt1) other = 1'b1;
            if (who ? bus.done1 : bus.done0) begin
                done_e = e;
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
                break;
            end
        end
        chk({tag, "_en_cycles"}, 32'(en_c), 32'd2);
        chk({tag, "_gnt_cycles"}, 32'(gnt_c), 32'd2);
        chk({tag, "_other_gnt"}, 32'(other), 32'd0);
        chk({tag, "_done_edge"}, 32'(done_e), 32'd3);
        @(posedge clock); #1;
        chk({tag, "_done_clear"}, 32'(bus.done0 | bus.done1), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int order [4];
        int n_g, en_c, done_e;
        bit p0, p1, seen;
        n_tests = 0; n_fail = 0;
        reset = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.rw0 = 0; bus.rw1 = 0; bus.size0 = 0; bus.size1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.rw0 = 0; bus1.rw1 = 0; bus1.size0 = 0; bus1.size1 = 0;
        bus1.addr0 = 0; bus1.addr1 = 0; bus1.wdata0 = 0; bus1.wdata1 = 0;

        repeat (2) @(negedge clock);
        chk("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        chk("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
        chk("rst_men", 32'({bus.m_en, bus.m_rw, bus.m_size}), 32'd0);
        chk("rst_mar", bus.mar, 32'd0);
        chk("rst_mdr", bus.mdr, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        run_access("rd32", 1'b0, 1'b1, 2'b11, 32'h0, 32'h0);
        chk("rd32_rdata", bus.rdata, 32'h12345678);

        run_access("wr8", 1'b1, 1'b0, 2'b00, 32'h40, 32'hAB);
        chk("wr8_rdata_held", bus.rdata, 32'h12345678);
        chk("wr8_mar", bus.mar, 32'h40);
        chk("wr8_mdr", bus.mdr, 32'hAB);
        run_access("rd8", 1'b1, 1'b1, 2'b00, 32'h40, 32'h0);
        chk("rd8_rdata", bus.rdata, 32'h000000AB);
        chk("rd8_size", 32'(bus.m_size), 32'd0);

        run_access("rd16", 1'b0, 1'b1, 2'b01, 32'h0, 32'h0);
        chk("rd16_rdata", bus.rdata, 32'h00005678);
        run_access("rd24", 1'b0, 1'b1, 2'b10, 32'h0, 32'h0);
        chk("rd24_rdata", bus.rdata, 32'h00345678);

        run_access("io", 1'b0, 1'b1, 2'b11, 32'h10000, 32'h0);
        chk("io_mar", bus.mar, 32'h10000);
        chk("io_rdata", bus.rdata, 32'hDEADBEEF);

        // request withdrawn and address changed right after the grant
        @(negedge clock);
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.size0 = 2'b11; bus.addr0 = 32'h0;
        @(posedge clock); #1;
        chk("wd_gnt", 32'(bus.gnt0), 32'd1);
        @(negedge clock);
        bus.req0 = 1'b0; bus.addr0 = 32'h80;
        seen = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock); #1;
            if (bus.done0) begin seen = 1'b1; break; end
        end
        chk("wd_done", 32'(seen), 32'd1);
        chk("wd_rdata", bus.rdata, 32'h12345678);
        chk("wd_mar", bus.mar, 32'h0);
        @(posedge clock); #1;

        // reset in the second ACCESS cycle of a write
        @(negedge clock);
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.size0 = 2'b11; bus.addr0 = 32'h44;
        bus.wdata0 = 32'h11223344;
        @(posedge clock); @(posedge clock); #2;
        chk("abort_men_before", 32'(bus.m_en), 32'd1);
        reset = 1'b1; #1;
        chk("abort_men", 32'(bus.m_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_gnt", 32'(bus.gnt0), 32'd0);
        chk("abort_mar", bus.mar, 32'd0);
        chk("abort_rdata", bus.rdata, 32'd0);
        bus.req0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (bus.done0 || bus.done1) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_access("post_rst", 1'b0, 1'b1, 2'b11, 32'h0, 32'h0);
        chk("post_rst_rdata", bus.rdata, 32'h12345678);

        // both requesters held continuously from a fresh reset
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.size0 = 2'b11; bus.addr0 = 32'h0;
        bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.size1 = 2'b11; bus.addr1 = 32'h40;
        for (int i = 0; i < 4; i++) order[i] = -1;
        n_g = 0; p0 = 1'b0; p1 = 1'b0;
        for (int e = 0; e < 60 && n_g < 4; e++) begin
            @(posedge clock); #1;
            if (bus.gnt0 && !p0) begin order[n_g] = 0; n_g++; end
            else if (bus.gnt1 && !p1) begin order[n_g] = 1; n_g++; end
            p0 = bus.gnt0; p1 = bus.gnt1;
        end
`ifdef ARB_RR_EN
        chk("tie_g0", 32'(order[0]), 32'd0);
        chk("tie_g1", 32'(order[1]), 32'd1);
        chk("tie_g2", 32'(order[2]), 32'd0);
        chk("tie_g3", 32'(order[3]), 32'd1);
`else
        chk("tie_g0", 32'(order[0]), 32'd0);
        chk("tie_g1", 32'(order[1]), 32'd0);
        chk("tie_g2", 32'(order[2]), 32'd0);
        chk("tie_g3", 32'(order[3]), 32'd0);
`endif
        @(negedge clock);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("tie_idle_busy", 32'(bus.busy), 32'd0);

        // single-cycle access on the ACC_TICKS=1 instance
        @(negedge clock);
        bus1.req0 = 1'b1; bus1.rw0 = 1'b1; bus1.size0 = 2'b11; bus1.addr0 = 32'h0;
        en_c = 0; done_e = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clock); #1;
            if (bus1.m_en) en_c++;
            if (bus1.done0) begin done_e = e; bus1.req0 = 1'b0; break; end
        end
        chk("t1_en_cycles", 32'(en_c), 32'd1);
        chk("t1_done_edge", 32'(done_e), 32'd2);
        chk("t1_rdata", bus1.rdata, 32'h5A5A0001);
        @(posedge clock); #1;
        chk("t1_done_clear", 32'(bus1.done0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ACC_TICKS, default 2, is the number of cycles m_en stays high per access; legal range 1..15.
REQ-002 clock  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req0/req1  in  1  access request from requester 0 (CPU) or requester 1 (loader/DMA).
REQ-005 rw0/rw1  in  1  access mode: 1 = read, 0 = write.
REQ-006 size0/size1  in  2  operand width: 11 = INT32, 10 = INT24, 01 = INT16, 00 = BYTE.
REQ-007 addr0/addr1, wdata0/wdata1  in  32  byte address and write data.
REQ-008 gnt0/gnt1  out  1  high while that requester owns the memory port.
REQ-009 done0/done1  out  1  one-cycle completion pulse.
REQ-010 rdata  out  32  captured read data.
REQ-011 m_en, m_rw  out  1 each; m_size  out  2; mar, mdr  out  32 each; together these drive the memory port.
REQ-012 dbus  in  32  read data returned by memory.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement three states (IDLE, ACCESS, DONE), and all outputs SHALL be registered.
REQ-015 Selection in IDLE with exactly one reqN high: at the next edge go to ACCESS, set gntN=1 and m_en=1, latch mar=addrN, mdr=wdataN, m_rw=rwN, m_size=sizeN, and load cnt=ACC_TICKS-1.
REQ-016 Handling in ACCESS: while cnt>0, decrement cnt; at the edge where cnt==0, set m_en=0, gntN=0, doneN=1 and state=DONE, and when m_rw=1 also set rdata=dbus.
REQ-017 Handling in DONE: at the next edge, clear doneN and return to IDLE; no grant is issued from DONE (one-cycle turnaround).
REQ-018 Timing: m_en SHALL be high for exactly ACC_TICKS cycles, and doneN SHALL rise ACC_TICKS+1 edges after the IDLE edge that samples reqN.
REQ-019 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter rdata.
REQ-020 A requester SHALL drop reqN in the cycle doneN is high, and a reqN still high when IDLE samples it SHALL be treated as a new request.
REQ-021 req, addr, wdata, rw and size SHALL be sampled only in IDLE; changes during ACCESS or DONE SHALL be ignored, and a request withdrawn mid-access SHALL still complete and pulse done.
REQ-022 gnt0 and gnt1 SHALL never be high together; done0 and done1 SHALL never be high together.
REQ-023 Addresses SHALL pass through unchecked, including IOADDR 'h10000 and addresses above MEMSIZE-4; an undriven dbus (Z) SHALL be captured as-is.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE and all of the following to 0: m_en, m_rw, m_size, mar, mdr, gnt0, gnt1, done0, done1, rdata, busy, cnt. It SHALL also set the last-grant pointer to 1.
REQ-025 Reset during ACCESS SHALL drop m_en in the same cycle, and the aborted access SHALL produce no done pulse.
REQ-026 The first IDLE sample SHALL occur at the first rising edge after reset deasserts.

Configuration
REQ-027 When ARB_RR_EN is defined, simultaneous requests SHALL be granted to the requester not granted most recently; the pointer resets to 1, so requester 0 wins the first tie.
REQ-028 When ARB_RR_EN is undefined, requester 0 SHALL always win simultaneous requests (fixed priority, requester 1 may starve), and the pointer logic SHALL be absent.

Verification
REQ-029 Read case: ACC_TICKS=2; req0, rw0=1, size0=INT32, addr0='h0 with memory 'h0='h12345678 -> m_en high 2 cycles, done0 pulses 1 cycle, rdata='h12345678.
REQ-030 Write-then-read case: req1, rw1=0, size1=BYTE, addr1='h40, wdata1='hAB, then a read of 'h40 with size BYTE -> rdata='h000000AB, gnt0 stays 0 throughout.
REQ-031 Simultaneous requests held continuously with ARB_RR_EN defined -> grants alternate 0,1,0,1 with one DONE cycle between grants; with ARB_RR_EN undefined -> only requester 0 is granted.
REQ-032 Reset asserted in the second ACCESS cycle -> m_en=0 immediately, no done pulse, busy=0, and a new req0 after reset completes normally.
REQ-033 req0 dropped one cycle after grant with addr0 changed to 'h80 -> access completes at the original address, done0 still pulses.
REQ-034 ACC_TICKS=1 with a single read -> m_en high 1 cycle, done0 rises 2 edges after the sampling edge.
